// File: rtl/serial_add_ctrl.sv
// Bit-serial add controller: captures two WIDTH-bit operands, adds them LSB-first
// through one full-adder slice, and returns {carry, result}. Macro SERIAL_ADD_SUB_EN adds subtract.
module serial_add_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic             s_bit,
    output logic             s_valid,
    output logic [WIDTH:0]   sum
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr, b_sr, r_sr;
    logic             c;
    logic [CW-1:0]    cnt;
    logic             bit_n, carry_n;
    logic [WIDTH-1:0] b_load;
    logic             c_load;

    assign bit_n   = a_sr[0] ^ b_sr[0] ^ c;
    assign carry_n = (a_sr[0] & b_sr[0]) | (a_sr[0] & c) | (b_sr[0] & c);
    assign s_valid = (state == SHIFT);
    // Outside SHIFT the slice still sees leftover carry; keep the serial bit quiet.
    assign s_bit   = s_valid & bit_n;

`ifdef SERIAL_ADD_SUB_EN
    // x - y == x + ~y + 1; the final carry is the no-borrow flag.
    assign b_load = sub ? ~y : y;
    assign c_load = sub;
`else
    assign b_load = y;
    assign c_load = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (reset) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            r_sr  <= '0;
            c     <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= x;
                        b_sr  <= b_load;
                        c     <= c_load;
                        cnt   <= '0;
                        r_sr  <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    c    <= carry_n;
                    r_sr <= {bit_n, r_sr[WIDTH-1:1]};
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        sum   <= {carry_n, bit_n, r_sr[WIDTH-1:1]};
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl at WIDTH=4 and WIDTH=8; a negedge monitor
// checks busy/s_valid/s_bit/done/sum against expected results queued by the driver.
`timescale 1ns/1ps
module tb_serial_add_ctrl;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       reset;
    logic       start4, start8;
    logic [3:0] x4, y4;
    logic [7:0] x8, y8;
    logic       busy4, done4, sbit4, sv4;
    logic       busy8, done8, sbit8, sv8;
    logic [4:0] sum4;
    logic [8:0] sum8;
`ifdef SERIAL_ADD_SUB_EN
    logic       sub4, sub8;
`endif

    serial_add_ctrl #(.WIDTH(4)) dut4 (
        .CLK(CLK), .reset(reset), .start(start4), .x(x4), .y(y4),
`ifdef SERIAL_ADD_SUB_EN
        .sub(sub4),
`endif
        .busy(busy4), .done(done4), .s_bit(sbit4), .s_valid(sv4), .sum(sum4));

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .CLK(CLK), .reset(reset), .start(start8), .x(x8), .y(y8),
`ifdef SERIAL_ADD_SUB_EN
        .sub(sub8),
`endif
        .busy(busy8), .done(done8), .s_bit(sbit8), .s_valid(sv8), .sum(sum8));

    typedef struct {
        logic [8:0] s;
        int         dc;
    } exp_t;

    exp_t       q[2][$];
    logic [8:0] last[2];
    int         cyc = 0;
    int         checks = 0;
    int         passed = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(string nm, logic [8:0] act, logic [8:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Result of the operation as arithmetic: sum, or {no_borrow, difference}.
    function automatic logic [8:0] model(int w, int a, int b, bit sb);
        int m = (1 << w) - 1;
        int am = a & m;
        int bm = b & m;
        if (sb) return 9'(((am >= bm) ? (1 << w) : 0) + ((am - bm) & m));
        return 9'(am + bm);
    endfunction

    // Monitor: expected busy window and done cycle follow from the queued start cycle.
    always @(negedge CLK) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                int         w;
                logic       bsy, dn, sb, sv, eb, ed;
                logic [8:0] sm;
                w   = k ? 8 : 4;
                bsy = k ? busy8 : busy4;
                dn  = k ? done8 : done4;
                sb  = k ? sbit8 : sbit4;
                sv  = k ? sv8 : sv4;
                sm  = k ? sum8 : {4'b0, sum4};
                if (q[k].size() > 0 && cyc > q[k][0].dc) begin
                    checks++;
                    $display("FAIL done_missing dut%0d expected done at cycle %0d, not asserted", w, q[k][0].dc);
                    void'(q[k].pop_front());
                end
                eb = q[k].size() > 0 && cyc >= q[k][0].dc - w && cyc < q[k][0].dc;
                ed = q[k].size() > 0 && cyc == q[k][0].dc;
                chk($sformatf("busy%0d", w), 9'(bsy), 9'(eb));
                chk($sformatf("s_valid%0d", w), 9'(sv), 9'(eb));
                if (eb) chk($sformatf("s_bit%0d", w), 9'(sb), 9'(q[k][0].s[cyc - (q[k][0].dc - w)]));
                chk($sformatf("done%0d", w), 9'(dn), 9'(ed));
                if (ed) begin
                    last[k] = q[k][0].s;
                    void'(q[k].pop_front());
                end
                chk($sformatf("sum%0d", w), sm, last[k]);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic set_in(int k, bit st, logic [7:0] a, logic [7:0] b, bit sb);
        if (k == 0) begin
            start4 = st; x4 = a[3:0]; y4 = b[3:0];
`ifdef SERIAL_ADD_SUB_EN
            sub4 = sb;
`endif
        end else begin
            start8 = st; x8 = a; y8 = b;
`ifdef SERIAL_ADD_SUB_EN
            sub8 = sb;
`endif
        end
    endtask

    task automatic push(int k, int a, int b, bit sb, int dc);
        exp_t e;
        e.s  = model(k ? 8 : 4, a, b, sb);
        e.dc = dc;
        q[k].push_back(e);
    endtask

    task automatic drain(int k);
        for (int n = 0; n < 40 && q[k].size() != 0; n++) tick();
        if (q[k].size() != 0) begin
            checks++;
            $display("FAIL drain dut%0d %0d results outstanding after timeout", k ? 8 : 4, q[k].size());
            q[k].delete();
        end
    endtask

    // One operation; during SHIFT the request inputs are scrambled and must be ignored.
    task automatic op(int k, int a, int b, bit sb);
        int w = k ? 8 : 4;
        set_in(k, 1'b1, 8'(a), 8'(b), sb);
        push(k, a, b, sb, cyc + 1 + w);
        tick();
        for (int i = 0; i < w; i++) begin
            set_in(k, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
            tick();
        end
        set_in(k, 1'b0, 8'h0, 8'h0, 1'b0);
        drain(k);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        q[0].delete(); q[1].delete();
        last[0] = '0; last[1] = '0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        set_in(0, 1'b0, 8'h0, 8'h0, 1'b0);
        set_in(1, 1'b0, 8'h0, 8'h0, 1'b0);
        last[0] = '0; last[1] = '0;
        tick(); tick();
        reset = 1'b0;
        chk("reset_busy", 9'(busy4), 9'd0);
        chk("reset_done", 9'(done4), 9'd0);
        chk("reset_s_valid", 9'(sv4), 9'd0);
        chk("reset_s_bit", 9'(sbit4), 9'd0);
        chk("reset_sum", 9'(sum4), 9'd0);
        tick();

        // Reset together with start: nothing accepted.
        reset = 1'b1;
        set_in(0, 1'b1, 8'd7, 8'd7, 1'b0);
        tick();
        reset = 1'b0;
        set_in(0, 1'b0, 8'h0, 8'h0, 1'b0);
        chk("rst_start_busy", 9'(busy4), 9'd0);
        repeat (6) tick();

        op(0, 9, 7, 1'b0);
        chk("sum_9_7", 9'(sum4), 9'b1_0000);
        op(0, 5, 6, 1'b0);
        chk("sum_5_6", 9'(sum4), 9'b0_1011);

        // Back-to-back with start held high.
        set_in(0, 1'b1, 8'd15, 8'd15, 1'b0);
        push(0, 15, 15, 1'b0, cyc + 5);
        push(0, 0, 0, 1'b0, cyc + 10);
        tick();
        set_in(0, 1'b1, 8'd0, 8'd0, 1'b0);
        repeat (5) tick();
        set_in(0, 1'b0, 8'd0, 8'd0, 1'b0);
        drain(0);
        chk("sum_b2b_second", 9'(sum4), 9'b0_0000);

        // Abort during bit 2.
        set_in(0, 1'b1, 8'd3, 8'd4, 1'b0);
        push(0, 3, 4, 1'b0, cyc + 5);
        tick();
        set_in(0, 1'b0, 8'd0, 8'd0, 1'b0);
        tick(); tick();
        do_reset();
        chk("abort_busy", 9'(busy4), 9'd0);
        chk("abort_done", 9'(done4), 9'd0);
        chk("abort_s_valid", 9'(sv4), 9'd0);
        chk("abort_sum", 9'(sum4), 9'd0);
        repeat (6) tick();
        op(0, 1, 1, 1'b0);
        chk("sum_1_1", 9'(sum4), 9'b0_0010);

`ifdef SERIAL_ADD_SUB_EN
        op(0, 5, 3, 1'b1);
        chk("sub_5_3", 9'(sum4), 9'b1_0010);
        op(0, 3, 5, 1'b1);
        chk("sub_3_5", 9'(sum4), 9'b0_1110);
        op(0, 0, 0, 1'b1);
        chk("sub_0_0", 9'(sum4), 9'b1_0000);
`endif

        for (int i = 0; i < 20; i++) begin
`ifdef SERIAL_ADD_SUB_EN
            op(0, $urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom_range(0, 1)));
`else
            op(0, $urandom_range(0, 15), $urandom_range(0, 15), 1'b0);
`endif
        end

        op(1, 200, 100, 1'b0);
        chk("sum8_200_100", sum8, 9'd300);
        op(1, 255, 255, 1'b0);
        for (int i = 0; i < 20; i++) begin
`ifdef SERIAL_ADD_SUB_EN
            op(1, $urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom_range(0, 1)));
`else
            op(1, $urandom_range(0, 255), $urandom_range(0, 255), 1'b0);
`endif
        end

        repeat (3) tick();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
